reg_bus_master: RTL

- Bus initiator for the lab register bus: the master side of the 5-channel WR_ADDR/WR_DATA/WR_BACK/RD_ADDR/RD_DATA protocol that peripheral slaves (DDS, etc.) respond to.
- Converts one local command (read or write burst) into a complete bus transaction, streams write data in and read data out, and reports the merged response.
- Sits between a local controller (command sequencer/UART bridge) and the bus interconnect.

---
 rtl/reg_bus_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/reg_bus_master.sv
// Lab register bus initiator: turns one local read/write burst command into a full
// WR_ADDR/WR_DATA/WR_BACK or RD_ADDR/RD_DATA transaction and reports a merged response.
module reg_bus_master #(
  parameter int unsigned ID_WIDTH        = 4,
  parameter logic [3:0]  WR_STRB_DEFAULT = 4'hF
) (
  input  logic                clk,
  input  logic                rstn,
  output logic                M_CLK,
  output logic                M_RSTN,
  // Local command / data side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ID_WIDTH-1:0] cmd_id,
  input  logic [31:0]         cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [1:0]          cmd_burst,
  input  logic [31:0]         wdata_in,
  input  logic                wdata_in_valid,
  output logic                wdata_in_ready,
  output logic [31:0]         rdata_out,
  output logic                rdata_out_last,
  output logic                rdata_out_valid,
  input  logic                rdata_out_ready,
  output logic                done_valid,
  output logic [1:0]          done_resp,
  // Write address channel
  output logic [ID_WIDTH-1:0] M_WR_ADDR_ID,
  output logic [31:0]         M_WR_ADDR,
  output logic [7:0]          M_WR_ADDR_LEN,
  output logic [1:0]          M_WR_ADDR_BURST,
  output logic                M_WR_ADDR_VALID,
  input  logic                M_WR_ADDR_READY,
  // Write data channel
  output logic [31:0]         M_WR_DATA,
  output logic [3:0]          M_WR_STRB,
  output logic                M_WR_DATA_LAST,
  output logic                M_WR_DATA_VALID,
  input  logic                M_WR_DATA_READY,
  // Write response channel
  input  logic [ID_WIDTH-1:0] M_WR_BACK_ID,
  input  logic [1:0]          M_WR_BACK_RESP,
  input  logic                M_WR_BACK_VALID,
  output logic                M_WR_BACK_READY,
  // Read address channel
  output logic [ID_WIDTH-1:0] M_RD_ADDR_ID,
  output logic [31:0]         M_RD_ADDR,
  output logic [7:0]          M_RD_ADDR_LEN,
  output logic [1:0]          M_RD_ADDR_BURST,
  output logic                M_RD_ADDR_VALID,
  input  logic                M_RD_ADDR_READY,
  // Read data channel
  input  logic [ID_WIDTH-1:0] M_RD_BACK_ID,
  input  logic [31:0]         M_RD_DATA,
  input  logic [1:0]          M_RD_DATA_RESP,
  input  logic                M_RD_DATA_LAST,
  input  logic                M_RD_DATA_VALID,
  output logic                M_RD_DATA_READY
);

  typedef enum logic [2:0] {
    StIdle, StWrAddr, StWrData, StWrResp, StRdAddr, StRdData, StDone
  } state_e;

  state_e              state_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [31:0]         addr_q;
  logic [7:0]          len_q;
  logic [1:0]          burst_q;
  logic [8:0]          beat_cnt_q;
  logic [1:0]          resp_acc_q;
  logic                wr_addr_valid_q;
  logic                rd_addr_valid_q;
  logic                done_valid_q;
  logic [1:0]          done_resp_q;

  logic       in_wr_data, in_rd_data, last_beat, wr_hs, rd_hs, rd_err;
  logic [1:0] wr_resp_nxt, rd_resp_nxt;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign in_wr_data = (state_q == StWrData);
  assign in_rd_data = (state_q == StRdData);
  assign last_beat  = (beat_cnt_q == {1'b0, len_q});
  assign wr_hs      = in_wr_data & wdata_in_valid & M_WR_DATA_READY;
  assign rd_hs      = in_rd_data & M_RD_DATA_VALID & rdata_out_ready;

  // A slave LAST that disagrees with the expected final beat is a protocol error either way.
  assign rd_err      = (M_RD_BACK_ID != id_q) | (last_beat != M_RD_DATA_LAST);
  assign rd_resp_nxt = resp_max(resp_max(resp_acc_q, M_RD_DATA_RESP), rd_err ? 2'b10 : 2'b00);
  assign wr_resp_nxt = resp_max(resp_max(resp_acc_q, M_WR_BACK_RESP),
                                (M_WR_BACK_ID != id_q) ? 2'b10 : 2'b00);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StIdle;
      id_q            <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      burst_q         <= '0;
      beat_cnt_q      <= '0;
      resp_acc_q      <= '0;
      wr_addr_valid_q <= 1'b0;
      rd_addr_valid_q <= 1'b0;
      done_valid_q    <= 1'b0;
      done_resp_q     <= '0;
    end else begin
      done_valid_q <= 1'b0;
      done_resp_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            id_q       <= cmd_id;
            addr_q     <= cmd_addr;
            len_q      <= cmd_len;
            burst_q    <= cmd_burst;
            beat_cnt_q <= '0;
            resp_acc_q <= '0;
            if (cmd_write) begin
              state_q         <= StWrAddr;
              wr_addr_valid_q <= 1'b1;
            end else begin
              state_q         <= StRdAddr;
              rd_addr_valid_q <= 1'b1;
            end
          end
        end
        StWrAddr: begin
          if (M_WR_ADDR_READY) begin
            wr_addr_valid_q <= 1'b0;
            state_q         <= StWrData;
          end
        end
        StWrData: begin
          if (wr_hs) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
            if (last_beat) state_q <= StWrResp;
          end
        end
        StWrResp: begin
          if (M_WR_BACK_VALID) begin
            resp_acc_q   <= wr_resp_nxt;
            done_valid_q <= 1'b1;
            done_resp_q  <= wr_resp_nxt;
            state_q      <= StDone;
          end
        end
        StRdAddr: begin
          if (M_RD_ADDR_READY) begin
            rd_addr_valid_q <= 1'b0;
            state_q         <= StRdData;
          end
        end
        StRdData: begin
          if (rd_hs) begin
            resp_acc_q <= rd_resp_nxt;
            beat_cnt_q <= beat_cnt_q + 9'd1;
            if (M_RD_DATA_LAST) begin
              done_valid_q <= 1'b1;
              done_resp_q  <= rd_resp_nxt;
              state_q      <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign M_CLK  = clk;
  assign M_RSTN = rstn;

  assign cmd_ready  = (state_q == StIdle);
  assign done_valid = done_valid_q;
  assign done_resp  = done_resp_q;

  assign M_WR_ADDR_ID    = id_q;
  assign M_WR_ADDR       = addr_q;
  assign M_WR_ADDR_LEN   = len_q;
  assign M_WR_ADDR_BURST = burst_q;
  assign M_WR_ADDR_VALID = wr_addr_valid_q;

  assign M_WR_DATA       = wdata_in;
  assign M_WR_STRB       = WR_STRB_DEFAULT;
  assign M_WR_DATA_LAST  = in_wr_data & last_beat;
  assign M_WR_DATA_VALID = in_wr_data & wdata_in_valid;
  assign wdata_in_ready  = in_wr_data & M_WR_DATA_READY;
  assign M_WR_BACK_READY = (state_q == StWrResp);

  assign M_RD_ADDR_ID    = id_q;
  assign M_RD_ADDR       = addr_q;
  assign M_RD_ADDR_LEN   = len_q;
  assign M_RD_ADDR_BURST = burst_q;
  assign M_RD_ADDR_VALID = rd_addr_valid_q;

  assign rdata_out       = M_RD_DATA;
  assign rdata_out_valid = in_rd_data & M_RD_DATA_VALID;
  assign rdata_out_last  = in_rd_data & M_RD_DATA_LAST;
  assign M_RD_DATA_READY = in_rd_data & rdata_out_ready;

endmodule
